dmem_port_master: RTL and testbench

Bus initiator for the 256-byte convolution data memory. It bulk-loads a pixel/kernel image from an upstream word stream into memory, and streams result words back out to a downstream consumer. It drives the memory's addr/write_data/memwrite/memread port while the core is held off via `hold_core`, and sits between the testbench/host link and the data memory, muxed ahead of the core's load/store path.

---
 rtl/dmem_master_pkg.sv | 31 +++
 rtl/dmem_out_buf.sv | 42 ++++
 rtl/dmem_port_master.sv | 166 ++++++++++++++++
 tb/tb_dmem_port_master.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_master_pkg.sv
// Shared types and constants for the data-memory port master.
// Memory geometry, default load/dump regions and the controller state encoding.
package dmem_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DUMP  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam int unsigned WORD_BYTES     = 4;
    localparam int unsigned MEM_BYTES      = 256;
    localparam int unsigned DEF_LOAD_BASE  = 60;
    localparam int unsigned DEF_LOAD_WORDS = 38;
    localparam int unsigned DEF_DUMP_BASE  = 0;
    localparam int unsigned DEF_DUMP_WORDS = 9;

    // Word counter width: a 256-byte memory holds at most 64 words.
    localparam int CNT_W = 8;

    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [CNT_W-1:0] idx);
        return base + (32'(idx) << 2);
    endfunction

    function automatic bit region_fits(input int unsigned base, input int unsigned words);
        return ((base % WORD_BYTES) == 0) && ((base + WORD_BYTES * words) <= MEM_BYTES);
    endfunction

endpackage

// File: rtl/dmem_out_buf.sv
// Single-entry valid/ready output register for the dump stream.
// free is high when a new word may be captured this cycle.
module dmem_out_buf #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         capture,
    input  logic [W-1:0] cap_data,
    input  logic         cap_last,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         free
);

    logic         valid_reg;
    logic [W-1:0] data_reg;
    logic         last_reg;

    assign free      = !valid_reg || out_ready;
    assign out_valid = valid_reg;
    assign out_data  = data_reg;
    assign out_last  = last_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
            last_reg  <= 1'b0;
        end else if (capture) begin
            valid_reg <= 1'b1;
            data_reg  <= cap_data;
            last_reg  <= cap_last;
        end else if (valid_reg && out_ready) begin
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
        end
    end

endmodule

// File: rtl/dmem_port_master.sv
// Bus initiator that bulk-loads the data memory from a word stream and dumps results out.
// Optional macro DMEM_MASTER_CHECKSUM_EN appends a wrap-around sum beat to every dump.
module dmem_port_master
    import dmem_master_pkg::*;
#(
    parameter int unsigned LOAD_BASE  = DEF_LOAD_BASE,
    parameter int unsigned LOAD_WORDS = DEF_LOAD_WORDS,
    parameter int unsigned DUMP_BASE  = DEF_DUMP_BASE,
    parameter int unsigned DUMP_WORDS = DEF_DUMP_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_load,
    input  logic        start_dump,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_last,
    input  logic        out_ready,
    output logic [31:0] addr,
    output logic [31:0] write_data,
    output logic        memwrite,
    output logic        memread,
    input  logic [31:0] read_data,
    output logic        hold_core,
    output logic        busy,
    output logic        done
);

    if (!region_fits(LOAD_BASE, LOAD_WORDS)) begin : g_load_region_bad
        $error("dmem_port_master: load region misaligned or outside memory");
    end
    if (!region_fits(DUMP_BASE, DUMP_WORDS)) begin : g_dump_region_bad
        $error("dmem_port_master: dump region misaligned or outside memory");
    end

    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_WORDS - 1);
    localparam logic [CNT_W-1:0] DUMP_CNT  = CNT_W'(DUMP_WORDS);
    localparam logic [CNT_W-1:0] DUMP_LAST = CNT_W'(DUMP_WORDS - 1);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             done_reg;

    logic        load_beat;
    logic        data_issue;
    logic        last_issue;
    logic        cap_en;
    logic [31:0] cap_data;
    logic        buf_free;

    assign load_beat  = (state_reg == ST_LOAD) && in_valid;
    assign data_issue = (state_reg == ST_DUMP) && (cnt_reg < DUMP_CNT) && buf_free;

`ifdef DMEM_MASTER_CHECKSUM_EN
    logic [31:0] acc_reg;
    logic        csum_issue;

    // Once every data word has been issued, the next free slot carries the sum.
    assign csum_issue = (state_reg == ST_DUMP) && (cnt_reg == DUMP_CNT) && buf_free;
    assign last_issue = csum_issue;
    assign cap_en     = data_issue || csum_issue;
    assign cap_data   = csum_issue ? acc_reg : read_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_reg <= '0;
        end else if (state_reg == ST_IDLE) begin
            acc_reg <= '0;
        end else if (data_issue) begin
            acc_reg <= acc_reg + read_data;
        end
    end
`else
    assign last_issue = data_issue && (cnt_reg == DUMP_LAST);
    assign cap_en     = data_issue;
    assign cap_data   = read_data;
`endif

    dmem_out_buf #(.W(32)) u_out_buf (
        .clk       (clk),
        .reset     (reset),
        .capture   (cap_en),
        .cap_data  (cap_data),
        .cap_last  (last_issue),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .free      (buf_free)
    );

    assign in_ready  = (state_reg == ST_LOAD);
    assign hold_core = (state_reg != ST_IDLE);
    assign busy      = hold_core;
    assign done      = done_reg;

    // Memory port is driven combinationally so a beat lands on the same edge it is accepted.
    always_comb begin
        memwrite   = 1'b0;
        memread    = 1'b0;
        addr       = '0;
        write_data = '0;
        if (load_beat) begin
            memwrite   = 1'b1;
            addr       = word_addr(32'(LOAD_BASE), cnt_reg);
            write_data = in_data;
        end else if (data_issue) begin
            memread = 1'b1;
            addr    = word_addr(32'(DUMP_BASE), cnt_reg);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    cnt_reg <= '0;
                    if (start_load) begin
                        state_reg <= ST_LOAD;
                    end else if (start_dump) begin
                        state_reg <= ST_DUMP;
                    end
                end
                ST_LOAD: begin
                    if (load_beat) begin
                        if (cnt_reg == LOAD_LAST) begin
                            state_reg <= ST_IDLE;
                            cnt_reg   <= '0;
                            done_reg  <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                ST_DUMP: begin
                    if (data_issue) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                    if (last_issue) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (out_valid && out_ready && out_last) begin
                        state_reg <= ST_IDLE;
                        cnt_reg   <= '0;
                        done_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_port_master.sv
// Directed self-checking bench for dmem_port_master with a behavioural 256-byte memory.
// Define DMEM_MASTER_CHECKSUM_EN to expect the extra checksum beat on dumps.
module tb_dmem_port_master;

`ifdef DMEM_MASTER_CHECKSUM_EN
    localparam int EXP_BEATS = 10;
`else
    localparam int EXP_BEATS = 9;
`endif

    logic clk;
    logic reset;

    logic        start_load, start_dump, in_valid, in_ready;
    logic [31:0] in_data;
    logic        out_valid, out_last, out_ready;
    logic [31:0] out_data;
    logic [31:0] addr, write_data, read_data;
    logic        memwrite, memread, hold_core, busy, done;

    logic        start_load_b, start_dump_b, in_valid_b, in_ready_b;
    logic [31:0] in_data_b;
    logic        out_valid_b, out_last_b, out_ready_b;
    logic [31:0] out_data_b;
    logic [31:0] addr_b, write_data_b, read_data_b;
    logic        memwrite_b, memread_b, hold_core_b, busy_b, done_b;

    logic [31:0] mem [0:63];
    logic        pre_we;
    logic [5:0]  pre_idx;
    logic [31:0] pre_data;

    int n_tests;
    int n_fail;
    int done_cnt;

    dmem_port_master u_dut (
        .clk(clk), .reset(reset),
        .start_load(start_load), .start_dump(start_dump),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .addr(addr), .write_data(write_data), .memwrite(memwrite), .memread(memread),
        .read_data(read_data), .hold_core(hold_core), .busy(busy), .done(done)
    );

    dmem_port_master #(.DUMP_BASE(60), .DUMP_WORDS(3)) u_dut_b (
        .clk(clk), .reset(reset),
        .start_load(start_load_b), .start_dump(start_dump_b),
        .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_b),
        .out_valid(out_valid_b), .out_data(out_data_b), .out_last(out_last_b), .out_ready(out_ready_b),
        .addr(addr_b), .write_data(write_data_b), .memwrite(memwrite_b), .memread(memread_b),
        .read_data(read_data_b), .hold_core(hold_core_b), .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign read_data   = mem[addr[7:2]];
    assign read_data_b = mem[addr_b[7:2]];

    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_data;
        else if (memwrite) mem[addr[7:2]] <= write_data;
    end

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic mem_wr(input int idx, input logic [31:0] data);
        pre_idx  = 6'(idx);
        pre_data = data;
        pre_we   = 1'b1;
        @(posedge clk); #1;
        pre_we   = 1'b0;
    endtask

    // Dump words first + step*i from words 0..8, releasing out_ready every 'period' cycles.
    task automatic run_dump(input logic [31:0] first, input logic [31:0] step,
                            input int period, input string tag);
        logic [31:0] exp;
        logic [31:0] sum;
        int nb;
        int viol;
        for (int i = 0; i < 9; i++) mem_wr(i, first + step * 32'(i));
        start_dump = 1'b1;
        @(posedge clk); #1;
        start_dump = 1'b0;
        nb = 0; sum = '0; viol = 0;
        for (int k = 0; k < 300 && !done; k++) begin
            out_ready = ((k % period) == 0);
            #1;
            if (memread && out_valid && !out_ready) viol++;
            if (out_valid && out_ready) begin
                exp = (nb < 9) ? first + step * 32'(nb) : sum;
                check({tag, "_data"}, out_data, exp);
                check({tag, "_last"}, {31'd0, out_last}, {31'd0, nb == EXP_BEATS - 1});
                if (nb < 9) sum = sum + exp;
                nb++;
            end
            @(posedge clk); #1;
        end
        check({tag, "_beats"}, 32'(nb), 32'(EXP_BEATS));
        check({tag, "_read_while_full"}, 32'(viol), 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        out_ready = 1'b1;
    endtask

    initial begin
        int d0;
        logic rd_seen;
        n_tests = 0; n_fail = 0; done_cnt = 0;
        reset = 1'b1;
        start_load = 0; start_dump = 0; in_valid = 0; in_data = '0; out_ready = 0;
        start_load_b = 0; start_dump_b = 0; in_valid_b = 0; in_data_b = '0; out_ready_b = 0;
        pre_we = 0; pre_idx = '0; pre_data = '0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_ctrl", {24'd0, in_ready, out_valid, out_last, memwrite, memread,
                           hold_core, busy, done}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_addr", addr, 32'd0);
        check("rst_write_data", write_data, 32'd0);
        check("rst_ctrl_b", {28'd0, out_valid_b, memread_b, busy_b, done_b}, 32'd0);
        reset = 1'b0;

        // Load 38 words with both starts high: load must win
        start_load = 1'b1; start_dump = 1'b1;
        @(posedge clk); #1;
        start_load = 1'b0; start_dump = 1'b0;
        check("load_entry_in_ready", {31'd0, in_ready}, 32'd1);
        check("load_entry_hold_busy", {30'd0, hold_core, busy}, 32'd3);
        for (int i = 0; i < 38; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h100 + 32'(i);
            #1;
            check("load_memwrite", {31'd0, memwrite}, 32'd1);
            check("load_addr", addr, 32'd60 + 32'(4 * i));
            check("load_wdata", write_data, 32'h100 + 32'(i));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("load_done_pulse", {31'd0, done}, 32'd1);
        check("load_idle_busy", {30'd0, busy, in_ready}, 32'd0);
        @(posedge clk); #1;
        check("load_done_single", {31'd0, done}, 32'd0);
        check("load_mem_60", mem[15], 32'h100);
        check("load_mem_208", mem[52], 32'h125);
        rd_seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (memread || out_valid || busy) rd_seen = 1'b1;
        end
        check("no_dump_after_dual_start", {31'd0, rd_seen}, 32'd0);
        check("load_done_count", 32'(done_cnt), 32'd1);

        // Dump of 3 words from byte 60 on the second instance
        mem_wr(15, 32'h19); mem_wr(16, 32'h64); mem_wr(17, 32'h7d);
        out_ready_b = 1'b1; start_dump_b = 1'b1;
        @(posedge clk); #1;
        start_dump_b = 1'b0;
        check("d3_first_issue", {31'd0, memread_b}, 32'd1);
        check("d3_first_addr", addr_b, 32'd60);
        check("d3_no_valid_yet", {31'd0, out_valid_b}, 32'd0);
        @(posedge clk); #1;
        check("d3_b0_valid", {31'd0, out_valid_b}, 32'd1);
        check("d3_b0", out_data_b, 32'h19);
        check("d3_b0_last", {31'd0, out_last_b}, 32'd0);
        check("d3_b1_addr", addr_b, 32'd64);
        @(posedge clk); #1;
        check("d3_b1", out_data_b, 32'h64);
        check("d3_b1_last", {31'd0, out_last_b}, 32'd0);
        @(posedge clk); #1;
        check("d3_b2", out_data_b, 32'h7d);
`ifdef DMEM_MASTER_CHECKSUM_EN
        check("d3_b2_last", {31'd0, out_last_b}, 32'd0);
        @(posedge clk); #1;
        check("d3_csum", out_data_b, 32'hfa);
        check("d3_csum_last", {31'd0, out_last_b}, 32'd1);
`else
        check("d3_b2_last", {31'd0, out_last_b}, 32'd1);
        check("d3_drain_no_read", {31'd0, memread_b}, 32'd0);
`endif
        @(posedge clk); #1;
        check("d3_done", {30'd0, done_b, out_valid_b}, 32'd2);

        // Dump 9 words with out_ready pattern 1,0,0
        run_dump(32'hC0DE_0000, 32'h0000_0011, 3, "bp_dump");

        // All-ones dump: checksum wraps to 0xFFFFFFF7 when enabled
        run_dump(32'hFFFF_FFFF, 32'd0, 1, "ones_dump");

        // Reset after 5 load beats
        start_load = 1'b1;
        @(posedge clk); #1;
        start_load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h200 + 32'(i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        reset = 1'b1;
        d0 = done_cnt;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_mid_idle", {29'd0, busy, in_ready, memwrite}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid_no_done", 32'(done_cnt), 32'(d0));
        for (int i = 0; i < 5; i++) check("rst_mid_mem", mem[15 + i], 32'h200 + 32'(i));
        check("rst_mid_mem_80_old", mem[20], 32'h105);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
